// File: rtl/nes_sram_ctrl.sv
// Byte-wide request bridge to a multiplexed async SRAM: low/mid address bytes are
// latched externally via two ALE strobes, with an optional cache that skips redundant phases.
module nes_sram_ctrl #(
   parameter int unsigned ALE_CYCLES    = 2,
   parameter int unsigned ACCESS_CYCLES = 3,
   parameter int unsigned ADDR_CACHE    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [19:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rdata_valid,
   output logic [7:0]  rdata,
   output logic [1:0]  sram_ale,
   output logic [3:0]  sram_adrh,
   output logic [7:0]  sram_do,
   input  logic [7:0]  sram_di,
   output logic        sram_bus_oen,
   output logic        sram_cen,
   output logic        sram_rdn,
   output logic        sram_wdn
);

   typedef enum logic [2:0] {
      IDLE, ALE_LO, HOLD_LO, ALE_HI, HOLD_HI, SETUP, ACCESS, RECOVER
   } state_t;

   localparam bit         CACHE_EN = (ADDR_CACHE != 0);
   localparam logic [3:0] ALE_LAST = 4'(ALE_CYCLES - 1);
   localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [15:0] addr_q, addr_n;
   logic        we_q, we_n;
   logic [7:0]  wdata_q, wdata_n;
   logic [7:0]  lo_q, hi_q;
   logic        lo_vld, hi_vld;
   logic        accept, skip_lo_req, skip_hi_req, skip_hi_q;
   logic [1:0]  ale_n;
   logic [7:0]  do_n;
   logic        oen_n, cen_n, rdn_n, wdn_n, rvalid_n;

   always_comb begin
      accept      = req_valid && req_ready;
      skip_lo_req = CACHE_EN && lo_vld && (req_addr[7:0] == lo_q);
      skip_hi_req = CACHE_EN && hi_vld && (req_addr[15:8] == hi_q);
      skip_hi_q   = CACHE_EN && hi_vld && (addr_q[15:8] == hi_q);
      addr_n      = accept ? req_addr[15:0] : addr_q;
      we_n        = accept ? req_we : we_q;
      wdata_n     = accept ? req_wdata : wdata_q;
   end

   always_comb begin
      state_n = state;
      cnt_n   = (cnt == '0) ? '0 : cnt - 4'd1;
      case (state)
         IDLE:
            if (accept) begin
               if (!skip_lo_req) begin
                  state_n = ALE_LO;
                  cnt_n   = ALE_LAST;
               end else if (!skip_hi_req) begin
                  state_n = ALE_HI;
                  cnt_n   = ALE_LAST;
               end else begin
                  state_n = SETUP;
               end
            end
         ALE_LO:  if (cnt == '0) state_n = HOLD_LO;
         HOLD_LO:
            if (skip_hi_q) begin
               state_n = ACCESS;
               cnt_n   = ACC_LAST;
            end else begin
               state_n = ALE_HI;
               cnt_n   = ALE_LAST;
            end
         ALE_HI:  if (cnt == '0) state_n = HOLD_HI;
         HOLD_HI, SETUP: begin
            state_n = ACCESS;
            cnt_n   = ACC_LAST;
         end
         ACCESS:  if (cnt == '0) state_n = RECOVER;
         RECOVER: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Pad values are decoded from the state being entered so every pad is a flop.
   always_comb begin
      ale_n    = '0;
      do_n     = '0;
      oen_n    = 1'b1;
      cen_n    = 1'b1;
      rdn_n    = 1'b1;
      wdn_n    = 1'b1;
      rvalid_n = 1'b0;
      case (state_n)
         ALE_LO: begin
            ale_n = 2'b01;
            do_n  = addr_n[7:0];
            oen_n = 1'b0;
         end
         HOLD_LO: begin
            do_n  = addr_n[7:0];
            oen_n = 1'b0;
         end
         ALE_HI: begin
            ale_n = 2'b10;
            do_n  = addr_n[15:8];
            oen_n = 1'b0;
         end
         HOLD_HI: begin
            do_n  = addr_n[15:8];
            oen_n = 1'b0;
         end
         ACCESS: begin
            cen_n = 1'b0;
            if (we_n) begin
               wdn_n = 1'b0;
               oen_n = 1'b0;
               do_n  = wdata_n;
            end else begin
               rdn_n = 1'b0;
            end
         end
         RECOVER: begin
            if (we_n) begin
               oen_n = 1'b0;
               do_n  = wdata_n;
            end else begin
               rvalid_n = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         lo_vld       <= 1'b0;
         hi_vld       <= 1'b0;
         req_ready    <= 1'b0;
         rdata_valid  <= 1'b0;
         rdata        <= '0;
         sram_ale     <= '0;
         sram_adrh    <= '0;
         sram_do      <= '0;
         sram_bus_oen <= 1'b1;
         sram_cen     <= 1'b1;
         sram_rdn     <= 1'b1;
         sram_wdn     <= 1'b1;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         addr_q       <= addr_n;
         we_q         <= we_n;
         wdata_q      <= wdata_n;
         req_ready    <= (state_n == IDLE);
         rdata_valid  <= rvalid_n;
         sram_ale     <= ale_n;
         sram_do      <= do_n;
         sram_bus_oen <= oen_n;
         sram_cen     <= cen_n;
         sram_rdn     <= rdn_n;
         sram_wdn     <= wdn_n;
         if (accept) sram_adrh <= req_addr[19:16];
         if (state == HOLD_LO) begin
            lo_q   <= addr_q[7:0];
            lo_vld <= 1'b1;
         end
         if (state == HOLD_HI) begin
            hi_q   <= addr_q[15:8];
            hi_vld <= 1'b1;
         end
         if (state == ACCESS && cnt == '0 && !we_q) rdata <= sram_di;
      end
   end

endmodule

// File: doc/nes_sram_ctrl.md
Name: nes_sram_ctrl

Overview:
- Bridges the NES core's single-byte memory requests to the external multiplexed asynchronous SRAM on the user IO pads.
- The low and middle address bytes go out on the shared 8-bit data bus and are captured by two external latches, strobed by sram_ale[0] and sram_ale[1]. Address bits [19:16] go out on sram_adrh.
- An optional address-latch cache skips ALE phases whose latched byte is already correct.
- The block drives the sram_* nets the top level maps onto io_out[23:7] and io_oeb[19:12].

Parameters:
- ALE_CYCLES, 2, cycles each ALE strobe is held high (1..15)
- ACCESS_CYCLES, 3, cycles sram_cen plus rdn/wdn are held low (1..15)
- ADDR_CACHE, 1, 1 = skip ALE phase when the latched byte already matches; 0 = always issue both phases

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller idle; request accepted when valid&&ready
- req_we  input  1  1 = write, 0 = read
- req_addr  input  20  byte address
- req_wdata  input  8  write data
- rdata_valid  output  1  one-cycle pulse: rdata holds read result
- rdata  output  8  read data, held until next read completes
- sram_ale  output  2  [0] low-byte latch strobe, [1] mid-byte latch strobe
- sram_adrh  output  4  address [19:16]
- sram_do  output  8  bus drive value
- sram_di  input  8  bus sampled value
- sram_bus_oen  output  1  0 = drive bus, 1 = tristate
- sram_cen  output  1  chip enable, active-low
- sram_rdn  output  1  output enable, active-low
- sram_wdn  output  1  write enable, active-low

Behaviour:
- All outputs are registered.
- Reset / IDLE values: req_ready=1 (0 while rst is asserted), rdata_valid=0, rdata=0, sram_ale=00, sram_adrh=0, sram_do=0, sram_bus_oen=1, sram_cen=sram_rdn=sram_wdn=1. Both cache-valid flags cleared.
- States: IDLE, ALE_LO, HOLD_LO, ALE_HI, HOLD_HI, SETUP, ACCESS, RECOVER. req_ready=1 only in IDLE.
- On accept (cycle 0): register addr, we, and wdata. sram_adrh=addr[19:16] from cycle 1 and held after the transaction.
- Skip rules (ADDR_CACHE=1):
  - skip_lo = lo_vld && addr[7:0]==lo_q
  - skip_hi = hi_vld && addr[15:8]==hi_q
- Next state after accept: ALE_LO unless skip_lo; else ALE_HI unless skip_hi; else SETUP.
- ALE_LO: ALE_CYCLES cycles; sram_do=addr[7:0], oen=0, ale=01. Then HOLD_LO, 1 cycle: ale=00, sram_do held. Next state is ALE_HI unless skip_hi, else ACCESS. On exit: lo_q<=addr[7:0], lo_vld<=1.
- ALE_HI / HOLD_HI: identical, using addr[15:8] and ale=10. On exit: update hi_q and hi_vld. Next state is ACCESS.
- SETUP: 1 cycle, bus tristated, strobes inactive. Gives adrh setup time when both phases are skipped. Next state is ACCESS.
- ACCESS: ACCESS_CYCLES cycles, cen=0.
  - Read: rdn=0, oen=1. sram_di is registered into rdata on the last ACCESS cycle.
  - Write: wdn=0, oen=0, sram_do=wdata.
- RECOVER: 1 cycle. cen=rdn=wdn=1.
  - Write: oen=0 and sram_do=wdata held (data hold time).
  - Read: oen=1, and rdata_valid=1 in this cycle only.
  - Next state is IDLE.
- Latency with defaults:
  - Full address: ALE_LO cycles 1-2, HOLD_LO 3, ALE_HI 4-5, HOLD_HI 6, ACCESS 7-9, RECOVER 10 (rdata_valid), req_ready=1 at cycle 11.
  - Both phases skipped: SETUP 1, ACCESS 2-4, RECOVER 5, ready at 6.
- The ALE strobe and any rdn/wdn strobe are never active in the same cycle. rdn and wdn are never both low.
- Writes and reads update the cache identically. The cache is invalidated only by rst.
- rst mid-transaction: next edge returns every output to its reset value, state goes to IDLE, and the cache is cleared. No rdata_valid is produced for the aborted request.
- Inputs other than req_valid are don't-care when not accepted. A request held valid during a busy period is accepted on the first IDLE cycle.

Test Plan:
- Reset, then read 0x12345 with sram_di=0xA5 during ACCESS -> ale=01 with do=0x45 at cycles 1-2; ale=10 with do=0x23 at cycles 4-5; adrh=0x1; rdn=0 at cycles 7-9; rdata_valid with rdata=0xA5 at cycle 10; ready at 11.
- Write 0x12346 data 0x3C right after the previous read -> ALE_LO issued (do=0x46), ALE_HI skipped; wdn=0 with do=0x3C, oen=0 for 3 cycles; data held through RECOVER.
- Read 0x12346 again -> both phases skipped; SETUP then ACCESS; rdata_valid 5 cycles after accept.
- ADDR_CACHE=0, two identical reads -> both ALE phases issued on each read.
- Assert rst during ACCESS of a read -> next cycle all outputs at reset values, no rdata_valid; following read to the same address issues both ALE phases.
- Hold req_valid continuously with alternating we -> exactly one accept per IDLE cycle; no cycle with rdn=0 and wdn=0, and none with a strobe active during ALE.
